aplic_msi_writer: RTL
=====================

APLIC_MSI_WRITER -- requirements
Module: aplic_msi_writer

Interface
REQ-001 Parameter NR_HARTS, default 1: number of target harts, i.e. IMSIC interrupt files per privilege level.
REQ-002 Parameter FIFO_DEPTH, default 4: MSI request buffer entries; power of two, at least 2.
REQ-003 Parameter HART_W, default max(1,$clog2(NR_HARTS)): width of the hart index.
REQ-004 Port i_clk, input, 1: clock; all logic is rising-edge.
REQ-005 Port ni_rst, input, 1: asynchronous active-low reset.
REQ-006 Ports i_msi_valid/o_msi_ready, input/output, 1 each: valid/ready handshake for one MSI request from the domain.
REQ-007 Port i_msi_hart, input, HART_W: target hart index.
REQ-008 Port i_msi_sdom, input, 1: 0 selects the M-level IMSIC, 1 selects the S-level IMSIC.
REQ-009 Port i_msi_eiid, input, 11: external interrupt identity.
REQ-010 Ports i_mmsiaddr_ppn/i_smsiaddr_ppn, input, 44 each: M-level and S-level IMSIC base PPNs (hart 0).
REQ-011 Ports o_aw_valid/i_aw_ready/o_aw_addr, output/input/output, 1/1/64: write address channel.
REQ-012 Ports o_w_valid/i_w_ready/o_w_data/o_w_strb, output/input/output/output, 1/1/32/4: write data channel.
REQ-013 Ports i_b_valid/o_b_ready/i_b_resp, input/output/input, 1/1/2: write response channel.
REQ-014 Port o_busy, output, 1: FIFO non-empty or FSM not IDLE.
REQ-015 Port o_err_cnt, output, 16: count of non-OKAY write responses (present only per REQ-030).

Function
REQ-016 A request is accepted on the cycle where i_msi_valid and o_msi_ready are both high; o_msi_ready is high exactly when the FIFO is not full.
REQ-017 Accepted requests are stored with their resolved address, computed at enqueue: {8'h0, ppn, 12'h0} + (hart << 12), where ppn is selected by i_msi_sdom; arithmetic is 64-bit and wraps modulo 2^64.
REQ-018 Data is the EIID zero-extended to 32 bits; o_w_strb is 4'hF.
REQ-019 FSM states: IDLE, ADDR_DATA, WAIT_B.
REQ-020 IDLE goes to ADDR_DATA on the cycle after the FIFO is non-empty; this pops the head into an issue register.
REQ-021 In ADDR_DATA, o_aw_valid and o_w_valid assert together; each is dropped independently after its own handshake, and neither is dropped before its handshake.
REQ-022 ADDR_DATA goes to WAIT_B once both handshakes are done, including when both complete in the same cycle.
REQ-023 In WAIT_B, o_b_ready is 1; on i_b_valid, the FSM goes to IDLE, or directly to ADDR_DATA with the next head if the FIFO is non-empty.
REQ-024 Only one write is outstanding at a time; ordering is strict FIFO.
REQ-025 Simultaneous enqueue and pop while full is not possible (ready is low when full); simultaneous enqueue and pop at any other level leaves the occupancy unchanged.
REQ-026 Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-027 Minimum latency from accept to o_aw_valid is 2 cycles.

Reset
REQ-028 While ni_rst is low: FIFO is empty, FSM is IDLE, and all valid/ready outputs, o_busy and o_err_cnt are 0; o_aw_addr, o_w_data and o_w_strb are 0.
REQ-029 A reset mid-transaction abandons the transaction immediately without waiting for a response; the interconnect is reset with the same ni_rst.

Configuration
REQ-030 Macro APLIC_MSI_ERR_CNT_EN defined: o_err_cnt exists and increments on each i_b_valid with i_b_resp != 2'b00, saturating at 16'hFFFF.
REQ-031 Macro APLIC_MSI_ERR_CNT_EN undefined: o_err_cnt port and counter are absent, and responses are consumed regardless of i_b_resp.

Structure
REQ-032 Package aplic_msi_pkg holds the msi_entry_t struct {addr[63:0], eiid[10:0]}, the FSM state enum, and the AXI_RESP_OKAY constant.
REQ-033 The buffer is sub-module aplic_msi_fifo, parameterized by entry type and depth, with push/pop/full/empty ports.

Verification
REQ-034 Reset: with ni_rst=0 mid-burst, all outputs are 0; after release, o_msi_ready=1 and o_busy=0.
REQ-035 Single MSI: mmsiaddr_ppn=0x28000, hart=3, sdom=0, eiid=5 gives aw_addr=0x28003000 and w_data=5; then b OKAY returns to IDLE.
REQ-036 S-domain: smsiaddr_ppn=0x29000, hart=0, eiid=0x7FF gives aw_addr=0x29000000 and w_data=0x7FF.
REQ-037 Backpressure: aw_ready is held 0 for 5 cycles while w_ready=1; w_valid drops after its handshake, aw_valid stays high, and exactly one write is issued.
REQ-038 Full: 5 requests with FIFO_DEPTH=4 and aw_ready=0 make o_msi_ready=0 after the 5th accept (4 queued plus 1 issuing); all 5 complete in order.
REQ-039 With APLIC_MSI_ERR_CNT_EN defined, 3 responses with b_resp=2'b10 give o_err_cnt=3, and a following OKAY leaves it at 3.

Source files
------------

// File: rtl/aplic_msi_pkg.sv
// Shared types for the APLIC MSI writer: queued request entry, write FSM states,
// AXI response code and the IMSIC interrupt-file address helper.
package aplic_msi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         EIID_W        = 11;

    typedef struct packed {
        logic [63:0]       addr;
        logic [EIID_W-1:0] eiid;
    } msi_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_WAIT_B    = 2'd2
    } msi_state_e;

    // Each hart owns one 4 KiB interrupt-file page above the hart-0 base page.
    function automatic logic [63:0] msi_addr(input logic [43:0] ppn, input logic [63:0] hart);
        return {8'h00, ppn, 12'h000} + (hart << 6'd12);
    endfunction

endpackage

// File: rtl/aplic_msi_fifo.sv
// Request buffer for the MSI writer; pointers carry one extra wrap bit so that
// full and empty can be told apart. DEPTH must be a power of two, at least 2.
module aplic_msi_fifo #(
    parameter type T_ENTRY = logic,
    parameter int  DEPTH   = 4
) (
    input  logic   i_clk,
    input  logic   ni_rst,
    input  logic   i_push,
    input  T_ENTRY i_data,
    input  logic   i_pop,
    output T_ENTRY o_data,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wptr;
    logic [PTR_W:0] r_rptr;
    T_ENTRY         r_mem [DEPTH];
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign o_data  = r_mem[r_rptr[PTR_W-1:0]];

    // Read and write pointers advance modulo 2*DEPTH.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage, cleared on reset so stale requests never reappear.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/aplic_msi_writer.sv
// APLIC MSI writer: buffers MSI requests and issues them one at a time as 32-bit
// AXI writes to the target IMSIC. Optional error counter: APLIC_MSI_ERR_CNT_EN.
module aplic_msi_writer
    import aplic_msi_pkg::*;
#(
    parameter int NR_HARTS   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int HART_W     = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1
) (
    input  logic              i_clk,
    input  logic              ni_rst,
    input  logic              i_msi_valid,
    output logic              o_msi_ready,
    input  logic [HART_W-1:0] i_msi_hart,
    input  logic              i_msi_sdom,
    input  logic [10:0]       i_msi_eiid,
    input  logic [43:0]       i_mmsiaddr_ppn,
    input  logic [43:0]       i_smsiaddr_ppn,
    output logic              o_aw_valid,
    input  logic              i_aw_ready,
    output logic [63:0]       o_aw_addr,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic [31:0]       o_w_data,
    output logic [3:0]        o_w_strb,
    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic [1:0]        i_b_resp,
    output logic              o_busy
`ifdef APLIC_MSI_ERR_CNT_EN
    ,
    output logic [15:0]       o_err_cnt
`endif
);

    msi_state_e  r_state;
    logic        r_active;
    msi_entry_t  w_enq_entry;
    msi_entry_t  w_head;
    logic [43:0] w_ppn;
    logic [63:0] w_hart_ext;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_b_hs;
    logic        w_aw_fin;
    logic        w_w_fin;

    // Address is resolved at enqueue so later PPN changes do not affect queued MSIs.
    assign w_ppn       = i_msi_sdom ? i_smsiaddr_ppn : i_mmsiaddr_ppn;
    assign w_hart_ext  = {{(64-HART_W){1'b0}}, i_msi_hart};
    assign w_enq_entry = '{addr: msi_addr(w_ppn, w_hart_ext), eiid: i_msi_eiid};

    assign o_msi_ready = r_active && !w_fifo_full;
    assign w_push      = i_msi_valid && o_msi_ready;
    assign w_b_hs      = o_b_ready && i_b_valid;
    assign w_pop       = !w_fifo_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_WAIT_B) && w_b_hs));
    assign w_aw_fin    = !o_aw_valid || i_aw_ready;
    assign w_w_fin     = !o_w_valid || i_w_ready;
    assign o_busy      = !w_fifo_empty || (r_state != ST_IDLE);

    aplic_msi_fifo #(
        .T_ENTRY (msi_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_push  (w_push),
        .i_data  (w_enq_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Holds o_msi_ready low while reset is asserted and for the first edge after.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Write FSM; AW and W are released independently, B is awaited before the next issue.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_state    <= ST_IDLE;
            o_aw_valid <= 1'b0;
            o_w_valid  <= 1'b0;
            o_b_ready  <= 1'b0;
            o_aw_addr  <= 64'h0;
            o_w_data   <= 32'h0;
            o_w_strb   <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_ADDR_DATA;
                    end
                end
                ST_ADDR_DATA: begin
                    if (o_aw_valid && i_aw_ready) begin
                        o_aw_valid <= 1'b0;
                    end
                    if (o_w_valid && i_w_ready) begin
                        o_w_valid <= 1'b0;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state   <= ST_WAIT_B;
                        o_b_ready <= 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    if (w_b_hs) begin
                        o_b_ready <= 1'b0;
                        r_state   <= w_pop ? ST_ADDR_DATA : ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    o_aw_valid <= 1'b0;
                    o_w_valid  <= 1'b0;
                    o_b_ready  <= 1'b0;
                end
            endcase
            // Popping the head always launches a fresh AW/W pair.
            if (w_pop) begin
                o_aw_addr  <= w_head.addr;
                o_w_data   <= {21'h0, w_head.eiid};
                o_w_strb   <= 4'hF;
                o_aw_valid <= 1'b1;
                o_w_valid  <= 1'b1;
            end
        end
    end

`ifdef APLIC_MSI_ERR_CNT_EN
    // Saturating count of non-OKAY write responses.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            o_err_cnt <= 16'h0;
        end else if (w_b_hs && (i_b_resp != AXI_RESP_OKAY) && (o_err_cnt != 16'hFFFF)) begin
            o_err_cnt <= o_err_cnt + 16'h1;
        end
    end
`else
    logic w_unused_resp;
    assign w_unused_resp = ^i_b_resp;
`endif

endmodule
